// File: rtl/rca_lsq.sv
// rca_lsq: in-order load/store queue between a PR module and a word memory port.
// Buffers requests in a circular FIFO, issues one memory operation at a time,
// steers store bytes onto lanes with byte enables, and extends load results.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   addr, data, fn3          request byte address, right-aligned store data, funct3
//   load, store, new_request request kind and valid
//   lsq_full                 queue full (request presented while high is dropped)
//   load_data, load_complete extended load result and its one-cycle valid pulse
//   mem_addr, mem_wdata      word address and lane-steered store data
//   mem_be, mem_load/_store  byte enables (0 for loads) and head entry kind
//   mem_req_valid/_ready     memory request handshake
//   mem_rdata, mem_rvalid    memory load response
module rca_lsq #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_load,
  output logic            mem_store,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  // Queue storage; contents are only observed through a valid head entry.
  logic [XLEN-1:0] r_q_addr [DEPTH];
  logic [XLEN-1:0] r_q_data [DEPTH];
  logic [2:0]      r_q_fn3  [DEPTH];
  logic            r_q_load [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t          r_state;
  logic [2:0]      r_ld_fn3;
  logic [1:0]      r_ld_off;
  logic [XLEN-1:0] r_load_data;
  logic            r_load_complete;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_req_valid;
  logic [XLEN-1:0] w_head_addr;
  logic [XLEN-1:0] w_head_data;
  logic [2:0]      w_head_fn3;
  logic            w_head_load;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_ext;

  // Occupancy decode from the registered count only.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign lsq_full = w_full;

  // Requests asking for both or neither kind are dropped.
  assign w_push = new_request && !w_full && (load ^ store);
  assign w_req_valid = (r_state == IDLE) && !w_empty;
  assign w_pop  = w_req_valid && mem_req_ready;

  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];
  assign w_head_fn3  = r_q_fn3[r_rd_ptr];
  assign w_head_load = r_q_load[r_rd_ptr];

  // Entry write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= addr;
      r_q_data[r_wr_ptr] <= data;
      r_q_fn3[r_wr_ptr]  <= fn3;
      r_q_load[r_wr_ptr] <= load;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory request fields, driven from the head entry while a request is offered.
  always_comb begin
    mem_req_valid = w_req_valid;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_be        = 4'b0000;
    mem_load      = 1'b0;
    mem_store     = 1'b0;
    if (w_req_valid) begin
      mem_addr  = {w_head_addr[XLEN-1:2], 2'b00};
      mem_load  = w_head_load;
      mem_store = !w_head_load;
      if (!w_head_load) begin
        unique case (w_head_fn3[1:0])
          2'b00: begin
            mem_wdata = {4{w_head_data[7:0]}};
            mem_be    = 4'b0001 << w_head_addr[1:0];
          end
          2'b01: begin
            mem_wdata = {2{w_head_data[15:0]}};
            mem_be    = w_head_addr[1] ? 4'b1100 : 4'b0011;
          end
          default: begin
            mem_wdata = w_head_data;
            mem_be    = 4'b1111;
          end
        endcase
      end
    end
  end

  // Load lane extraction and extension using the offset/fn3 latched at issue.
  assign w_byte = mem_rdata[{r_ld_off, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_ld_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_ext = mem_rdata;
    unique case (r_ld_fn3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // Issue FSM: one outstanding operation; loads park in WAIT_LOAD for the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_ld_fn3        <= 3'b000;
      r_ld_off        <= 2'b00;
      r_load_data     <= '0;
      r_load_complete <= 1'b0;
    end else begin
      r_load_complete <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop && w_head_load) begin
            r_ld_fn3 <= w_head_fn3;
            r_ld_off <= w_head_addr[1:0];
            r_state  <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            r_load_data     <= w_load_ext;
            r_load_complete <= 1'b1;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_data     = r_load_data;
  assign load_complete = r_load_complete;

endmodule

// File: tb/tb_rca_lsq.sv
// tb_rca_lsq: directed self-checking bench for rca_lsq.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
module tb_rca_lsq;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  fn3;
  logic        load;
  logic        store;
  logic        new_request;
  logic        lsq_full;
  logic [31:0] load_data;
  logic        load_complete;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_load;
  logic        mem_store;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int n_cmp;
  int n_err;

  rca_lsq #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .data          (data),
    .fn3           (fn3),
    .load          (load),
    .store         (store),
    .new_request   (new_request),
    .lsq_full      (lsq_full),
    .load_data     (load_data),
    .load_complete (load_complete),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_load      (mem_load),
    .mem_store     (mem_store),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     input logic ld, input logic st);
    addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1'b1;
  endtask

  task automatic idle_req();
    new_request = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  // Load round trip: request, issue, response one cycle after issue, result one cycle later.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] rd, input logic [31:0] exp);
    mem_req_ready = 1'b1;
    req(a, 32'h0, f, 1'b1, 1'b0);
    step();
    idle_req();
    chk({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_isld"}, 32'(mem_load), 32'd1);
    step();
    chk({tag, "_wait_valid"}, 32'(mem_req_valid), 32'd0);
    mem_rdata = rd; mem_rvalid = 1'b1;
    chk({tag, "_early_cmp"}, 32'(load_complete), 32'd0);
    step();
    mem_rvalid = 1'b0;
    chk({tag, "_cmp"}, 32'(load_complete), 32'd1);
    chk({tag, "_data"}, load_data, exp);
    step();
    chk({tag, "_cmp_pulse"}, 32'(load_complete), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, input logic [31:0] exp_wd, input logic [3:0] exp_be);
    mem_req_ready = 1'b1;
    req(a, d, f, 1'b0, 1'b1);
    step();
    idle_req();
    chk({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_isst"}, 32'(mem_store), 32'd1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_wdata"}, mem_wdata, exp_wd);
    chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    step();
    chk({tag, "_retired"}, 32'(mem_req_valid), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    addr = '0; data = '0; fn3 = '0; load = 1'b0; store = 1'b0; new_request = 1'b0;
    mem_req_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    step();
    step();
    chk("rst_full", 32'(lsq_full), 32'd0);
    chk("rst_cmp", 32'(load_complete), 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_ld", 32'(mem_load), 32'd0);
    chk("rst_st", 32'(mem_store), 32'd0);
    rst = 1'b0;
    step();

    // Loads
    do_load("lw",  32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  32'h0000_0103, 3'b000, 32'h80FF_7F01, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0103, 3'b100, 32'h80FF_7F01, 32'h0000_0080);
    do_load("lh",  32'h0000_0102, 3'b001, 32'h80FF_7F01, 32'hFFFF_80FF);
    do_load("lhu", 32'h0000_0102, 3'b101, 32'h80FF_7F01, 32'h0000_80FF);
    do_load("lb0", 32'h0000_0100, 3'b000, 32'h80FF_7F01, 32'h0000_0001);
    do_load("lh0", 32'h0000_0101, 3'b001, 32'h80FF_7F01, 32'h0000_7F01);

    // Stores
    do_store("sb", 32'h0000_0201, 3'b000, 32'h1234_5678, 32'h7878_7878, 4'b0010);
    do_store("sh", 32'h0000_0202, 3'b001, 32'h1234_5678, 32'h5678_5678, 4'b1100);
    do_store("sh0", 32'h0000_0201, 3'b001, 32'h1234_5678, 32'h5678_5678, 4'b0011);
    do_store("sw", 32'h0000_0207, 3'b010, 32'h1234_5678, 32'h1234_5678, 4'b1111);

    // Fill under backpressure: four accepted, fifth dropped.
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("fill_full_before5", 32'(lsq_full), 32'd1);
      req(32'h300 + 32'(4 * i), 32'(i), 3'b010, 1'b0, 1'b1);
      step();
    end
    idle_req();
    chk("fill_full", 32'(lsq_full), 32'd1);
    chk("fill_head", mem_addr, 32'h300);
    mem_req_ready = 1'b1;
    step();
    chk("fill_full_drop", 32'(lsq_full), 32'd0);
    for (int i = 1; i < 4; i++) begin
      chk("fill_order_valid", 32'(mem_req_valid), 32'd1);
      chk("fill_order_addr", mem_addr, 32'h300 + 32'(4 * i));
      chk("fill_order_wdata", mem_wdata, 32'(i));
      step();
    end
    chk("fill_fifth_dropped", 32'(mem_req_valid), 32'd0);

    // Pointer wrap: one push and one pop per cycle.
    for (int i = 0; i < 10; i++) begin
      req(32'h400 + 32'(4 * i), 32'h0, 3'b010, 1'b0, 1'b1);
      step();
      chk("wrap_valid", 32'(mem_req_valid), 32'd1);
      chk("wrap_addr", mem_addr, 32'h400 + 32'(4 * i));
      chk("wrap_notfull", 32'(lsq_full), 32'd0);
    end
    idle_req();
    step();
    chk("wrap_drained", 32'(mem_req_valid), 32'd0);

    // Illegal request with both kinds set.
    req(32'h600, 32'h0, 3'b010, 1'b1, 1'b1);
    step();
    idle_req();
    chk("illegal_noenq", 32'(mem_req_valid), 32'd0);

    // Stray response in IDLE is ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_ign", 32'(load_complete), 32'd0);

    // Reset while a load is outstanding and a store is queued.
    mem_req_ready = 1'b1;
    req(32'h500, 32'h0, 3'b010, 1'b1, 1'b0);
    step();
    req(32'h504, 32'hAAAA_5555, 3'b010, 1'b0, 1'b1);
    step();
    idle_req();
    chk("rstw_waiting", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk("rstw_no_cmp", 32'(load_complete), 32'd0);
    chk("rstw_valid", 32'(mem_req_valid), 32'd0);
    chk("rstw_full", 32'(lsq_full), 32'd0);
    chk("rstw_ldata", load_data, 32'd0);
    step();
    chk("rstw_no_cmp2", 32'(load_complete), 32'd0);
    chk("rstw_empty", 32'(mem_req_valid), 32'd0);

    // Queue is usable after reset.
    do_load("post_rst_lw", 32'h0000_0700, 3'b010, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
